// File: rtl/vga_apb_arbiter.sv
// Two-master round-robin APB arbiter in front of the VGA framebuffer slave; one transfer in flight.
// Optional ACCESS-phase watchdog is built only when VGA_ARB_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module vga_apb_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_paddr,
    input  logic                m0_psel,
    input  logic                m0_penable,
    input  logic                m0_pwrite,
    input  logic [DATA_W-1:0]   m0_pwdata,
    input  logic [DATA_W/8-1:0] m0_pstrb,
    input  logic [2:0]          m0_pprot,
    output logic                m0_pready,
    output logic [DATA_W-1:0]   m0_prdata,
    output logic                m0_pslverr,
    input  logic [ADDR_W-1:0]   m1_paddr,
    input  logic                m1_psel,
    input  logic                m1_penable,
    input  logic                m1_pwrite,
    input  logic [DATA_W-1:0]   m1_pwdata,
    input  logic [DATA_W/8-1:0] m1_pstrb,
    input  logic [2:0]          m1_pprot,
    output logic                m1_pready,
    output logic [DATA_W-1:0]   m1_prdata,
    output logic                m1_pslverr,
    output logic [ADDR_W-1:0]   out_paddr,
    output logic [DATA_W-1:0]   out_pwdata,
    output logic [DATA_W/8-1:0] out_pstrb,
    output logic [2:0]          out_pprot,
    output logic                out_pwrite,
    output logic                out_psel,
    output logic                out_penable,
    input  logic                out_pready,
    input  logic                out_pslverr,
    input  logic [DATA_W-1:0]   out_prdata
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              busy, done, expire, resp_vld;
    logic              resp_pslverr, m0_deliver, m1_deliver;
    logic [DATA_W-1:0] resp_prdata;
    logic              unused_inputs;

    // Requests are psel alone; penable from the masters carries no information here.
    assign unused_inputs = ^{m0_penable, m1_penable, TIMEOUT[0]};

`ifdef VGA_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP) begin
            cnt_d = '0;
        end else if ((state_q == ACCESS) && !out_pready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the TIMEOUT-th ACCESS cycle; a real out_pready that cycle still takes priority.
    assign expire = (state_q == ACCESS) && !out_pready && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
    assign expire = 1'b0;
`endif

    assign done         = (state_q == ACCESS) && out_pready;
    assign resp_vld     = done || expire;
    assign resp_prdata  = done ? out_prdata : '0;
    assign resp_pslverr = done ? out_pslverr : expire;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (m0_psel || m1_psel) begin
                    state_d = SETUP;
                    grant_d = (m0_psel && m1_psel) ? ~last_grant_q : m1_psel;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (resp_vld) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign busy        = (state_q == SETUP) || (state_q == ACCESS);
    assign out_psel    = busy;
    assign out_penable = (state_q == ACCESS);
    assign out_paddr   = !busy ? '0 : (grant_q ? m1_paddr  : m0_paddr);
    assign out_pwdata  = !busy ? '0 : (grant_q ? m1_pwdata : m0_pwdata);
    assign out_pstrb   = !busy ? '0 : (grant_q ? m1_pstrb  : m0_pstrb);
    assign out_pprot   = !busy ? '0 : (grant_q ? m1_pprot  : m0_pprot);
    assign out_pwrite  = busy && (grant_q ? m1_pwrite : m0_pwrite);

    // A master that dropped psel mid-transfer gets no response.
    assign m0_deliver = resp_vld && !grant_q && m0_psel;
    assign m1_deliver = resp_vld &&  grant_q && m1_psel;

    assign m0_pready  = m0_deliver;
    assign m0_prdata  = m0_deliver ? resp_prdata : '0;
    assign m0_pslverr = m0_deliver && resp_pslverr;
    assign m1_pready  = m1_deliver;
    assign m1_prdata  = m1_deliver ? resp_prdata : '0;
    assign m1_pslverr = m1_deliver && resp_pslverr;
endmodule

// File: tb/tb_vga_apb_arbiter.sv
// Directed and randomized bench for vga_apb_arbiter with a transaction-level round-robin model.
`timescale 1ns/1ps
module tb_vga_apb_arbiter;
    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] m0_paddr, m0_pwdata, m0_prdata, m1_paddr, m1_pwdata, m1_prdata;
    logic        m0_psel, m0_penable, m0_pwrite, m0_pready, m0_pslverr;
    logic        m1_psel, m1_penable, m1_pwrite, m1_pready, m1_pslverr;
    logic [3:0]  m0_pstrb, m1_pstrb, out_pstrb;
    logic [2:0]  m0_pprot, m1_pprot, out_pprot;
    logic [31:0] out_paddr, out_pwdata, out_prdata;
    logic        out_pwrite, out_psel, out_penable, out_pready, out_pslverr;

    // Per-master pending transaction, as the model sees it.
    logic [31:0] ta[2], td[2];
    logic [3:0]  ts[2];
    logic [2:0]  tp[2];
    logic        tw[2], tpsel[2];
    bit          pend[2];
    int          last_g;
    int          total = 0, passes = 0;

    assign m0_paddr = ta[0]; assign m0_pwdata = td[0]; assign m0_pstrb = ts[0];
    assign m0_pprot = tp[0]; assign m0_pwrite = tw[0]; assign m0_psel = tpsel[0];
    assign m1_paddr = ta[1]; assign m1_pwdata = td[1]; assign m1_pstrb = ts[1];
    assign m1_pprot = tp[1]; assign m1_pwrite = tw[1]; assign m1_psel = tpsel[1];
    assign m0_penable = 1'b0;
    assign m1_penable = 1'b0;

    vga_apb_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n),
        .m0_paddr(m0_paddr), .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
        .m0_pwdata(m0_pwdata), .m0_pstrb(m0_pstrb), .m0_pprot(m0_pprot),
        .m0_pready(m0_pready), .m0_prdata(m0_prdata), .m0_pslverr(m0_pslverr),
        .m1_paddr(m1_paddr), .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
        .m1_pwdata(m1_pwdata), .m1_pstrb(m1_pstrb), .m1_pprot(m1_pprot),
        .m1_pready(m1_pready), .m1_prdata(m1_prdata), .m1_pslverr(m1_pslverr),
        .out_paddr(out_paddr), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb),
        .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_psel(out_psel),
        .out_penable(out_penable), .out_pready(out_pready), .out_pslverr(out_pslverr),
        .out_prdata(out_prdata)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passes = passes + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic setreq(input int i, input logic [31:0] a, input logic [31:0] d, input logic wr);
        ta[i] = a; td[i] = d; ts[i] = 4'($urandom); tp[i] = 3'($urandom);
        tw[i] = wr; tpsel[i] = 1'b1; pend[i] = 1'b1;
    endtask

    // Starts at posedge+1 with the arbiter idle; runs one complete arbitrated transfer.
    task automatic xfer(input int w, input logic [31:0] rd, input logic er, input bit drop);
        int g;
        bit exp_rdy;
        g = (pend[0] && pend[1]) ? (1 - last_g) : (pend[1] ? 1 : 0);
        @(negedge clock);
        chk("idle_psel", 32'(out_psel), 32'(0));
        chk("idle_paddr", out_paddr, 32'h0);
        chk("idle_rdy", 32'({m1_pready, m0_pready}), 32'(0));
        @(posedge clock); #1;
        @(negedge clock);
        chk("setup_ctl", 32'({out_psel, out_penable}), 32'(2'b10));
        chk("setup_paddr", out_paddr, ta[g]);
        chk("setup_pwdata", out_pwdata, td[g]);
        chk("setup_attr", 32'({out_pwrite, out_pstrb, out_pprot}), 32'({tw[g], ts[g], tp[g]}));
        chk("setup_rdy", 32'({m1_pready, m0_pready}), 32'(0));
        for (int k = 0; k <= w; k++) begin
            @(posedge clock); #1;
            if (drop) tpsel[g] = 1'b0;
            out_pready  = (k == w);
            out_prdata  = (k == w) ? rd : $urandom;
            out_pslverr = (k == w) ? er : 1'($urandom_range(0, 1));
            @(negedge clock);
            exp_rdy = (k == w) && !drop;
            chk("acc_ctl", 32'({out_psel, out_penable}), 32'(2'b11));
            chk("acc_paddr", out_paddr, ta[g]);
            chk("win_rdy", 32'(g ? m1_pready : m0_pready), 32'(exp_rdy));
            chk("win_rdata", g ? m1_prdata : m0_prdata, exp_rdy ? rd : 32'h0);
            chk("win_err", 32'(g ? m1_pslverr : m0_pslverr), 32'(exp_rdy && er));
            chk("lose_rdy", 32'(g ? {m0_pready, m0_pslverr} : {m1_pready, m1_pslverr}), 32'(0));
            chk("lose_rdata", g ? m0_prdata : m1_prdata, 32'h0);
        end
        @(posedge clock); #1;
        out_pready = 1'b0; out_prdata = 32'h0; out_pslverr = 1'b0;
        tpsel[g] = 1'b0; pend[g] = 1'b0; last_g = g;
    endtask

    initial begin : main
        for (int i = 0; i < 2; i++) begin
            ta[i] = '0; td[i] = '0; ts[i] = '0; tp[i] = '0; tw[i] = 1'b0;
            tpsel[i] = 1'b0; pend[i] = 1'b0;
        end
        out_pready = 1'b0; out_prdata = 32'h0; out_pslverr = 1'b0;
        last_g = 1;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_ctl", 32'({out_psel, out_penable}), 32'(0));
        chk("rst_rdy", 32'({m0_pready, m0_pslverr, m1_pready, m1_pslverr}), 32'(0));
        chk("rst_rdata", m0_prdata | m1_prdata, 32'h0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Single write with zero wait states: latency and write-data pass-through.
        setreq(0, 32'h2100_0010, 32'h00FF_0000, 1'b1);
        xfer(0, 32'h0, 1'b0, 1'b0);

        // Both masters always requesting: strict alternation.
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 2; i++)
                if (!pend[i]) setreq(i, $urandom, $urandom, 1'b1);
            xfer(0, $urandom, 1'b0, 1'b0);
        end

        // m1 read with three wait states.
        setreq(1, 32'h2100_0200, 32'h0, 1'b0);
        xfer(3, 32'hDEAD_BEEF, 1'b0, 1'b0);

        // Sync-register write answered with pslverr, followed by a normal m1 transfer.
        setreq(0, 32'h211F_FFF4, 32'h0000_0001, 1'b1);
        setreq(1, $urandom, $urandom, 1'b1);
        xfer(0, 32'h0, 1'b1, 1'b0);
        xfer(1, $urandom, 1'b0, 1'b0);

        // m0 abandons its transfer mid-way; the slot still counts for fairness.
        setreq(0, $urandom, $urandom, 1'b1);
        xfer(1, $urandom, 1'b0, 1'b1);
        setreq(0, $urandom, $urandom, 1'b1);
        setreq(1, $urandom, $urandom, 1'b0);
        xfer(0, $urandom, 1'b0, 1'b0);
        xfer(0, $urandom, 1'b0, 1'b0);

        // Randomized mix of requesters, wait states, responses and drops.
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 2; i++)
                if (!pend[i] && $urandom_range(0, 1) == 1)
                    setreq(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
            if (!pend[0] && !pend[1]) setreq($urandom_range(0, 1), $urandom, $urandom, 1'b0);
            xfer($urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end

        // Reset asserted during ACCESS, then a tie must go to m0.
        setreq(1, $urandom, $urandom, 1'b1);
        @(negedge clock);
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(negedge clock);
        chk("pre_rst_acc", 32'({out_psel, out_penable}), 32'(2'b11));
        #1 reset_n = 1'b0;
        #1 chk("rst_abort", 32'({out_psel, out_penable}), 32'(0));
        tpsel[0] = 1'b0; tpsel[1] = 1'b0; pend[0] = 1'b0; pend[1] = 1'b0;
        last_g = 1;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock); #1;
        setreq(0, 32'h2100_0040, $urandom, 1'b1);
        setreq(1, 32'h2100_0080, $urandom, 1'b1);
        xfer(0, $urandom, 1'b0, 1'b0);
        xfer(0, $urandom, 1'b0, 1'b0);

`ifdef VGA_ARB_TIMEOUT_EN
        // Slave never answers: watchdog completes the transfer with an error.
        setreq(0, $urandom, $urandom, 1'b1);
        @(negedge clock);
        @(posedge clock); #1;
        @(negedge clock);
        for (int k = 1; k <= TO; k++) begin
            @(posedge clock); #1;
            out_pready = 1'b0;
            out_prdata = $urandom | 32'h1;
            @(negedge clock);
            chk("tmo_rdy", 32'(m0_pready), 32'(k == TO));
            chk("tmo_err", 32'(m0_pslverr), 32'(k == TO));
            chk("tmo_rdata", m0_prdata, 32'h0);
        end
        @(posedge clock); #1;
        tpsel[0] = 1'b0; pend[0] = 1'b0; last_g = 0;
        @(negedge clock);
        chk("tmo_idle", 32'({out_psel, out_penable}), 32'(0));
        @(posedge clock); #1;
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
